microop_tracer: RTL and testbench

- Passive tracer on the controller-to-datapath control word.
- Decodes the per-step micro-operations (`xsrc`, `xdst`, `we`, `end_sq`) plus the internal bus value back into one record per executed instruction.
- Buffers records in a small FIFO that the monitor drains with a valid/ready handshake.
- Sits beside the controller in the CPU top level, driving nothing into the CPU.

---
 rtl/microop_tracer_pkg.sv | 24 ++
 rtl/microop_tracer_fifo.sv | 42 ++++
 rtl/microop_tracer.sv | 115 +++++++++++
 tb/tb_microop_tracer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/microop_tracer_pkg.sv
// microop_tracer_pkg: shared control-word bit positions, record field widths and collector states.
// Entry widths are given for both builds: plain (ENTRY_W) and with TRACER_STAMP_EN (ENTRY_W_STAMP).
package microop_tracer_pkg;
    localparam int XDST_PC  = 0;
    localparam int XDST_A   = 1;
    localparam int XDST_B   = 2;
    localparam int XDST_C   = 3;
    localparam int XDST_MA  = 4;
    localparam int XDST_WD  = 5;
    localparam int XDST_I   = 6;
    localparam int XDST_T   = 7;
    localparam int XDST_R   = 8;
    localparam int XDST_FLG = 9;
    localparam logic [2:0] XSRC_PC = 3'd0;
    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam int PC_W    = 8;
    localparam int OP_W    = 8;
    localparam int STEPS_W = 4;
    localparam int DST_W   = 10;
    localparam int STAMP_W = 16;
    localparam int ENTRY_W       = PC_W + OP_W + STEPS_W + DST_W + 1;
    localparam int ENTRY_W_STAMP = ENTRY_W + STAMP_W;
    typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/microop_tracer_fifo.sv
// trace_fifo: first-word-fall-through record FIFO.
// Ports: clock, reset (sync, active-high); push/din write; pop consumes the head;
// dout is the head entry (zero while empty); full, empty, level (occupancy 0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [4:0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic wr, rd;
    assign full  = level == 5'(DEPTH);
    assign empty = level == 5'd0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign dout  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            level <= level + 5'(wr) - 5'(rd);
        end
    end
endmodule

// File: rtl/microop_tracer.sv
// microop_tracer: passive decoder of controller micro-steps into per-instruction trace records.
// Ports: clock, reset (sync, active-high); xsrc/xdst/we/end_sq/pause_cc/bus observe the control word;
// rec_valid/rec_ready drain the record FIFO whose head is rec_pc/rec_op/rec_steps/rec_dst/rec_we
// (plus rec_stamp when TRACER_STAMP_EN is defined); level, sticky overflow and sticky halted report status.
module microop_tracer
    import microop_tracer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  xsrc,
    input  logic [9:0]  xdst,
    input  logic        we,
    input  logic        end_sq,
    input  logic        pause_cc,
    input  logic [7:0]  bus,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [7:0]  rec_pc,
    output logic [7:0]  rec_op,
    output logic [3:0]  rec_steps,
    output logic [9:0]  rec_dst,
    output logic        rec_we,
`ifdef TRACER_STAMP_EN
    output logic [15:0] rec_stamp,
`endif
    output logic [4:0]  level,
    output logic        overflow,
    output logic        halted
);
`ifdef TRACER_STAMP_EN
    localparam int EW = ENTRY_W_STAMP;
`else
    localparam int EW = ENTRY_W;
`endif
    state_t state, state_n;
    logic [7:0] cur_pc, cur_op, op_n;
    logic       op_seen, we_acc, we_n;
    logic [3:0] steps, steps_n;
    logic [9:0] dst_acc, dst_n;
    logic       fetch_start, restart, halt_now, push, pop, full, empty;
    logic [EW-1:0] din, dout;
    assign fetch_start = xsrc == XSRC_PC && xdst[XDST_MA];
    // A fetch-start without end_sq while collecting abandons the partial record.
    assign restart  = fetch_start && (state == IDLE || !end_sq);
    assign op_n     = xdst[XDST_I] && !op_seen ? bus : cur_op;
    assign steps_n  = steps == 4'd15 ? steps : steps + 4'd1;
    assign dst_n    = dst_acc | xdst;
    assign we_n     = we_acc | we;
    assign halt_now = state == COLLECT && !halted && !restart && xdst[XDST_I] && !op_seen && bus == OP_HALT;
    assign push     = state == COLLECT && !halted && !halt_now && !restart && end_sq;
    assign pop      = rec_valid && rec_ready;
    assign rec_valid = !empty;
    always_comb begin
        state_n = state;
        if (state == IDLE && fetch_start) state_n = COLLECT;
        else if (push) state_n = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cur_pc   <= '0;
            cur_op   <= '0;
            op_seen  <= 1'b0;
            steps    <= '0;
            dst_acc  <= '0;
            we_acc   <= 1'b0;
            halted   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            halted   <= halted | halt_now;
            overflow <= overflow | (push && full && !pop);
            if (!halted) begin
                if (restart) begin
                    cur_pc  <= bus;
                    cur_op  <= '0;
                    op_seen <= 1'b0;
                    steps   <= 4'd1;
                    dst_acc <= xdst;
                    we_acc  <= we;
                end else if (state == COLLECT) begin
                    cur_op  <= op_n;
                    op_seen <= op_seen | xdst[XDST_I];
                    steps   <= steps_n;
                    dst_acc <= dst_n;
                    we_acc  <= we_n;
                end
            end
        end
    end
`ifdef TRACER_STAMP_EN
    logic [15:0] stamp;
    always_ff @(posedge clock) stamp <= reset ? '0 : pause_cc ? stamp : stamp + 16'd1;
    assign din = {cur_pc, op_n, steps_n, dst_n, we_n, stamp};
    assign {rec_pc, rec_op, rec_steps, rec_dst, rec_we, rec_stamp} = dout;
`else
    logic unused_pause;
    assign unused_pause = pause_cc;
    assign din = {cur_pc, op_n, steps_n, dst_n, we_n};
    assign {rec_pc, rec_op, rec_steps, rec_dst, rec_we} = dout;
`endif
    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(level)
    );
endmodule

// File: tb/tb_microop_tracer.sv
// tb_microop_tracer: table vectors, corner sequences and random instructions checked against a queue model.
module tb_microop_tracer;
    localparam int DEPTH = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [2:0] xsrc = '0;
    logic [9:0] xdst = '0;
    logic we = 1'b0, end_sq = 1'b0, pause_cc = 1'b0, rec_ready = 1'b0;
    logic [7:0] bus = '0;
    logic rec_valid, rec_we, overflow, halted;
    logic [7:0] rec_pc, rec_op;
    logic [3:0] rec_steps;
    logic [9:0] rec_dst;
    logic [4:0] level;
`ifdef TRACER_STAMP_EN
    logic [15:0] rec_stamp;
`endif
    always #5 clock = ~clock;

    microop_tracer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .xsrc(xsrc), .xdst(xdst), .we(we), .end_sq(end_sq),
        .pause_cc(pause_cc), .bus(bus), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_pc(rec_pc), .rec_op(rec_op), .rec_steps(rec_steps), .rec_dst(rec_dst), .rec_we(rec_we),
`ifdef TRACER_STAMP_EN
        .rec_stamp(rec_stamp),
`endif
        .level(level), .overflow(overflow), .halted(halted)
    );

    typedef struct {
        logic [7:0] pc, op;
        logic [3:0] steps;
        logic [9:0] dst;
        logic we;
        logic [15:0] stamp;
    } rec_t;
    typedef struct {
        logic [2:0] xsrc;
        logic [9:0] xdst;
        logic we, end_sq;
        logic [7:0] bus;
        logic rdy, pause, rst, push, halt;
    } stim_t;
    typedef struct {
        logic [7:0] pc, op;
        int n, we_step, wd_step;
        logic [3:0] e_steps;
        logic [9:0] e_dst;
        logic e_we;
    } vec_t;

    rec_t q[$];
    logic movf = 1'b0, mhalt = 1'b0;
    logic [15:0] cnt = '0;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one micro-step, advances the model by one posedge, then compares.
    task automatic step(input stim_t st, input rec_t rr);
        @(negedge clock);
        xsrc = st.xsrc; xdst = st.xdst; we = st.we; end_sq = st.end_sq; bus = st.bus;
        rec_ready = st.rdy; pause_cc = st.pause; reset = st.rst;
        @(posedge clock);
        if (st.rst) begin
            q.delete(); movf = 1'b0; mhalt = 1'b0; cnt = '0;
        end else begin
            if (st.rdy && q.size() > 0) void'(q.pop_front());
            rr.stamp = cnt;
            if (st.push) begin
                if (q.size() < DEPTH) q.push_back(rr);
                else movf = 1'b1;
            end
            if (st.halt) mhalt = 1'b1;
            if (!st.pause) cnt++;
        end
        #1;
        chk("valid", 32'(rec_valid), 32'(q.size() > 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("halted", 32'(halted), 32'(mhalt));
        if (q.size() > 0) begin
            chk("head_pc", 32'(rec_pc), 32'(q[0].pc));
            chk("head_op", 32'(rec_op), 32'(q[0].op));
            chk("head_steps", 32'(rec_steps), 32'(q[0].steps));
            chk("head_dst", 32'(rec_dst), 32'(q[0].dst));
            chk("head_we", 32'(rec_we), 32'(q[0].we));
`ifdef TRACER_STAMP_EN
            chk("head_stamp", 32'(rec_stamp), 32'(q[0].stamp));
`endif
        end
    endtask

    task automatic rst_cycle();
        stim_t st; rec_t rr;
        st = '{default: 0}; rr = '{default: 0};
        st.rst = 1'b1;
        step(st, rr);
    endtask

    task automatic idle(input int k, input logic r);
        stim_t st; rec_t rr;
        for (int i = 0; i < k; i++) begin
            st = '{default: 0}; rr = '{default: 0};
            st.xsrc = 3'd1; st.rdy = r;
            step(st, rr);
        end
    endtask

    task automatic raw(input logic [2:0] s, input logic [9:0] d, input logic e, input logic [7:0] b,
                       input logic p, input logic h);
        stim_t st; rec_t rr;
        st = '{default: 0}; rr = '{default: 0};
        st.xsrc = s; st.xdst = d; st.end_sq = e; st.bus = b; st.pause = p; st.halt = h;
        step(st, rr);
    endtask

    // rm: 0 ready low, 1 random ready, 2 ready only on the end_sq step.
    task automatic run_instr(input logic [7:0] pc, input logic [7:0] op, input int n, input int we_step,
                             input int wd_step, input bit rnd, input int rm);
        stim_t st; rec_t rr;
        logic [9:0] acc; logic wacc;
        acc = '0; wacc = 1'b0; rr = '{default: 0};
        for (int i = 0; i < n; i++) begin
            st = '{default: 0};
            if (i == 0) begin
                st.xsrc = 3'd0; st.xdst = 10'h010; st.bus = pc;
            end else if (i == 1) begin
                st.xsrc = 3'd4; st.xdst = 10'h040; st.bus = op;
            end else if (rnd) begin
                st.xsrc = 3'($urandom_range(1, 7)); st.xdst = 10'($urandom);
                st.we = ($urandom_range(0, 3) == 0); st.bus = 8'($urandom);
            end else begin
                st.xsrc = 3'd2;
            end
            if (i == wd_step) st.xdst |= 10'h020;
            if (i == we_step) st.we = 1'b1;
            st.end_sq = (i == n - 1);
            st.push = st.end_sq;
            st.rdy = rm == 1 ? 1'($urandom_range(0, 1)) : (rm == 2 && i == n - 1);
            st.pause = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc |= st.xdst; wacc |= st.we;
            rr.pc = pc; rr.op = op; rr.steps = n > 15 ? 4'd15 : 4'(n); rr.dst = acc; rr.we = wacc;
            step(st, rr);
        end
    endtask

    initial begin
        vec_t tv[5];
        logic [7:0] o;
        tv[0] = '{8'h10, 8'h01, 4, -1, -1, 4'd4, 10'h050, 1'b0};
        tv[1] = '{8'h20, 8'h0B, 9, 6, 5, 4'd9, 10'h070, 1'b1};
        tv[2] = '{8'h30, 8'h22, 17, -1, -1, 4'd15, 10'h050, 1'b0};
        tv[3] = '{8'hFE, 8'h7F, 3, -1, -1, 4'd3, 10'h050, 1'b0};
        tv[4] = '{8'h05, 8'hC3, 2, -1, -1, 4'd2, 10'h050, 1'b0};
        rst_cycle();
        rst_cycle();
        chk("rst_pc", 32'(rec_pc), 0);
        chk("rst_op", 32'(rec_op), 0);
        chk("rst_steps", 32'(rec_steps), 0);
        chk("rst_dst", 32'(rec_dst), 0);
        chk("rst_we", 32'(rec_we), 0);
`ifdef TRACER_STAMP_EN
        chk("rst_stamp", 32'(rec_stamp), 0);
`endif
        for (int i = 0; i < 5; i++) begin
            run_instr(tv[i].pc, tv[i].op, tv[i].n, tv[i].we_step, tv[i].wd_step, 1'b0, 0);
            chk("tv_valid", 32'(rec_valid), 1);
            chk("tv_pc", 32'(rec_pc), 32'(tv[i].pc));
            chk("tv_op", 32'(rec_op), 32'(tv[i].op));
            chk("tv_steps", 32'(rec_steps), 32'(tv[i].e_steps));
            chk("tv_dst", 32'(rec_dst), 32'(tv[i].e_dst));
            chk("tv_we", 32'(rec_we), 32'(tv[i].e_we));
            idle(1, 1'b1);
        end
        rst_cycle();
        for (int i = 0; i < 5; i++) run_instr(8'(8'h50 + i), 8'h11, 4, -1, -1, 1'b0, 0);
        chk("ovf_level", 32'(level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(rec_pc), 32'h50);
        idle(5, 1'b1);
        rst_cycle();
        for (int i = 0; i < 4; i++) run_instr(8'(8'h60 + i), 8'h12, 4, -1, -1, 1'b0, 0);
        run_instr(8'h64, 8'h12, 4, -1, -1, 1'b0, 2);
        chk("full_pp_level", 32'(level), 4);
        chk("full_pp_ovf", 32'(overflow), 0);
        chk("full_pp_head", 32'(rec_pc), 32'h61);
        idle(5, 1'b1);
        chk("full_pp_drained", 32'(level), 0);
        rst_cycle();
        raw(3'd0, 10'h010, 1'b0, 8'h70, 1'b0, 1'b0);
        raw(3'd4, 10'h040, 1'b0, 8'h02, 1'b0, 1'b0);
        raw(3'd2, 10'h001, 1'b0, 8'h33, 1'b0, 1'b0);
        rst_cycle();
        run_instr(8'h80, 8'h03, 5, -1, -1, 1'b0, 0);
        chk("rstmid_level", 32'(level), 1);
        chk("rstmid_pc", 32'(rec_pc), 32'h80);
        chk("rstmid_steps", 32'(rec_steps), 5);
        raw(3'd0, 10'h010, 1'b0, 8'h90, 1'b0, 1'b0);
        raw(3'd4, 10'h040, 1'b0, 8'h44, 1'b0, 1'b0);
        run_instr(8'h98, 8'h05, 4, -1, -1, 1'b0, 0);
        chk("malf_level", 32'(level), 2);
        idle(1, 1'b1);
        chk("malf_pc", 32'(rec_pc), 32'h98);
        chk("malf_op", 32'(rec_op), 32'h05);
        idle(1, 1'b1);
        rst_cycle();
        repeat (150) begin
            o = 8'($urandom_range(0, 254));
            run_instr(8'($urandom), o, $urandom_range(2, 18), -1, -1, 1'b1, 1);
            idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        idle(6, 1'b1);
        rst_cycle();
        run_instr(8'hA0, 8'h01, 4, -1, -1, 1'b0, 0);
        raw(3'd0, 10'h010, 1'b0, 8'hA4, 1'b0, 1'b0);
        raw(3'd4, 10'h040, 1'b0, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) raw(3'd1, 10'h000, 1'b1, 8'h00, 1'b1, 1'b0);
        raw(3'd0, 10'h010, 1'b1, 8'hB0, 1'b1, 1'b0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_level", 32'(level), 1);
        chk("halt_head", 32'(rec_pc), 32'hA0);
        rst_cycle();
        chk("halt_cleared", 32'(halted), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
